// File: rtl/acoustic_uart_pkg.sv
// rtl/acoustic_uart_pkg.sv - shared timing constants and feeder FSM encoding
package acoustic_uart_pkg;

  localparam int unsigned UART_CLK_FREQ    = 50_000_000;
  localparam int unsigned UART_BAUD        = 115200;
  localparam int unsigned UART_FRAME_CHARS = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2,
    ST_HOLD = 2'd3
  } feed_state_t;

  // 10 bit times per character (start + 8 data + stop) plus a safety margin
  function automatic int unsigned guard_cycles(input int unsigned clk_freq,
                                               input int unsigned baud,
                                               input int unsigned chars,
                                               input int unsigned margin);
    return chars * 10 * (clk_freq / baud) + margin;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy output
module sync_fifo
  import acoustic_uart_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_level
);

  localparam int unsigned    DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the indices match
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_frame_feeder.sv
// rtl/uart_frame_feeder.sv - queues result words and paces them into the decimal UART sender
module uart_frame_feeder #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned CLK_FREQ     = acoustic_uart_pkg::UART_CLK_FREQ,
  parameter int unsigned BAUD         = acoustic_uart_pkg::UART_BAUD,
  parameter int unsigned FRAME_CHARS  = acoustic_uart_pkg::UART_FRAME_CHARS,
  parameter int unsigned GUARD_MARGIN = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              uart_ready,
  output logic              uart_ena,
  output logic [DATA_W-1:0] uart_data,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  input  logic              clr_overflow
);

  import acoustic_uart_pkg::*;

  localparam int unsigned     GUARD     = guard_cycles(CLK_FREQ, BAUD, FRAME_CHARS, GUARD_MARGIN);
  localparam int unsigned     CNT_W     = $clog2(GUARD + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]  FULL_LVL  = (ADDR_W + 1)'(FIFO_DEPTH);

  feed_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;
  logic              r_uart_ena, w_uart_ena_nxt;
  logic [DATA_W-1:0] r_uart_data, w_uart_data_nxt;
  logic              r_overflow;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [ADDR_W:0]   w_level;

  sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_push    (in_valid),
    .i_wdata   (in_data),
    .i_pop     (w_pop),
    .o_rdata   (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  assign in_ready   = (w_level != FULL_LVL);
  assign fifo_level = w_level;
  assign uart_ena   = r_uart_ena;
  assign uart_data  = r_uart_data;
  assign overflow   = r_overflow;

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_uart_ena_nxt  = r_uart_ena;
    w_uart_data_nxt = r_uart_data;
    w_pop           = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_pop           = 1'b1;
        w_uart_data_nxt = w_head;
        w_uart_ena_nxt  = 1'b1;
        w_state_nxt     = ST_REQ;
      end
      // No timeout: the sender is trusted to accept eventually
      ST_REQ: if (uart_ready) begin
        w_uart_ena_nxt = 1'b0;
        w_hold_cnt_nxt = HOLD_LOAD;
        w_state_nxt    = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_hold_cnt == '0) w_state_nxt = ST_IDLE;
        else                  w_hold_cnt_nxt = r_hold_cnt - CNT_ONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_hold_cnt  <= '0;
      r_uart_ena  <= 1'b0;
      r_uart_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_uart_ena  <= w_uart_ena_nxt;
      r_uart_data <= w_uart_data_nxt;
    end
  end

  // A fresh drop outranks a clear in the same cycle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)              r_overflow <= 1'b0;
    else if (in_valid && w_full) r_overflow <= 1'b1;
    else if (clr_overflow)       r_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_frame_feeder.sv
// tb/tb_uart_frame_feeder.sv - self-checking bench for uart_frame_feeder
module tb_uart_frame_feeder;

  localparam int GUARD = 6 * 10 * (1_000_000 / 100_000) + 16;
  localparam int DEPTH = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        uart_ready = 1'b0;
  logic        uart_ena;
  logic [15:0] uart_data;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        clr_overflow = 1'b0;

  uart_frame_feeder #(
    .CLK_FREQ     (1_000_000),
    .BAUD         (100_000),
    .GUARD_MARGIN (16)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .uart_ready   (uart_ready),
    .uart_ena     (uart_ena),
    .uart_data    (uart_data),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a word queue plus the edge index at which the feeder is idle again
  logic [15:0] q[$];
  bit          m_ena, m_ovf, m_load;
  logic [15:0] m_data;
  longint      m_free_at, cyc;
  int          m_age;

  bit          auto_rdy = 1'b0;
  bit          rand_mode = 1'b0;
  int          rdly = 2;
  bit          prev_ena = 1'b0;
  longint      rises[$];
  logic [15:0] rise_data[$];

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ena = 0; m_ovf = 0; m_load = 0; m_data = '0; m_free_at = -1; m_age = 0;
    prev_ena = 0;
  endfunction

  function automatic bit m_in_hold();
    return !m_ena && !m_load && (cyc <= m_free_at);
  endfunction

  function automatic bit m_idle_empty();
    return !m_ena && !m_load && (cyc > m_free_at) && (q.size() == 0);
  endfunction

  function automatic void model_edge();
    bit was_full, was_empty;
    cyc++;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (m_load) begin
      m_data = q.pop_front();
      m_ena  = 1; m_age = 0; m_load = 0;
    end else if (m_ena) begin
      if (uart_ready) begin
        m_ena = 0;
        m_free_at = cyc + GUARD;
      end
    end else if (cyc > m_free_at && !was_empty) begin
      m_load = 1;
    end
    if (m_ena) m_age++;
    if (in_valid) begin
      if (was_full) m_ovf = 1;
      else          q.push_back(in_data);
    end else if (clr_overflow) begin
      m_ovf = 0;
    end
    if (in_valid && !was_full && clr_overflow) m_ovf = 0;
  endfunction

  task automatic cycle();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    chk("ena",      uart_ena,   m_ena);
    chk("data",     uart_data,  m_data);
    chk("level",    fifo_level, q.size());
    chk("overflow", overflow,   m_ovf);
    chk("in_ready", in_ready,   q.size() != DEPTH);
    if (uart_ena && !prev_ena) begin
      rises.push_back(cyc);
      rise_data.push_back(uart_data);
    end
    prev_ena = uart_ena;
    if (auto_rdy) begin
      if (rand_mode && m_ena && m_age == 1) rdly = $urandom_range(1, 4);
      uart_ready = (m_ena && m_age == rdly) ||
                   (rand_mode && !m_ena && $urandom_range(0, 49) == 0);
    end
  endtask

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          r;
    bit          c;
    bit          e_ena;
    logic [15:0] e_data;
    int          e_lvl;
    bit          e_ovf;
  } vec_t;

  vec_t tbl[9];
  int   hold_seen;
  int   budget;

  initial begin
    tbl[0] = '{0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0};
    tbl[1] = '{1, 16'h3039, 0, 0, 0, 16'h0000, 1, 0};
    tbl[2] = '{0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0};
    tbl[3] = '{0, 16'h0000, 0, 0, 1, 16'h3039, 0, 0};
    tbl[4] = '{0, 16'h0000, 0, 0, 1, 16'h3039, 0, 0};
    tbl[5] = '{0, 16'h0000, 1, 0, 0, 16'h3039, 0, 0};
    tbl[6] = '{0, 16'h0000, 1, 0, 0, 16'h3039, 0, 0};
    tbl[7] = '{1, 16'h1111, 0, 0, 0, 16'h3039, 1, 0};
    tbl[8] = '{0, 16'h0000, 0, 1, 0, 16'h3039, 1, 0};

    cyc = 0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    chk("rst_ena", uart_ena, 0);
    chk("rst_data", uart_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    sys_rst_n = 1'b1;

    // Single word, stray ready in IDLE and HOLD, table-driven
    hold_seen = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d;
      uart_ready = tbl[i].r; clr_overflow = tbl[i].c;
      cycle();
      chk($sformatf("tbl%0d_ena", i),   uart_ena,   tbl[i].e_ena);
      chk($sformatf("tbl%0d_data", i),  uart_data,  tbl[i].e_data);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_ovf", i),   overflow,   tbl[i].e_ovf);
      if (uart_data == 16'h3039) hold_seen++;
    end
    in_valid = 0; uart_ready = 0; clr_overflow = 0;

    auto_rdy = 1; rdly = 2;
    budget = 0;
    while (!(m_in_hold() && q.size() == 0 && m_data == 16'h1111) && budget < 2000) begin
      cycle();
      if (uart_data == 16'h3039) hold_seen++;
      budget++;
    end
    chk("t1_reach_hold_timeout", budget < 2000, 1);
    chk("t1_hold_len_ok", hold_seen >= GUARD, 1);

    // Stray ready pulses during HOLD, then a 4-word burst
    auto_rdy = 0;
    uart_ready = 1;
    repeat (3) cycle();
    uart_ready = 0;
    rises.delete(); rise_data.delete();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = 16'(i);
      cycle();
    end
    in_valid = 0;
    chk("t2_peak_level", fifo_level, 4);
    auto_rdy = 1;
    budget = 0;
    while (!(rises.size() == 4 && m_idle_empty()) && budget < 4000) begin
      cycle();
      budget++;
    end
    chk("t2_drain_timeout", budget < 4000, 1);
    chk("t2_rise_count", rises.size(), 4);
    for (int i = 0; i < rises.size(); i++) begin
      chk($sformatf("t2_word%0d", i), rise_data[i], i + 1);
      if (i > 0) chk($sformatf("t2_gap%0d_ok", i), (rises[i] - rises[i-1]) >= GUARD + 3, 1);
    end

    // Overflow with stalled sender: word 0 parks in REQ, 16 fill the FIFO, word 17 is lost
    auto_rdy = 0; uart_ready = 0;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1; in_data = 16'h0100 + 16'(i);
      cycle();
    end
    in_valid = 0;
    chk("t3_level_full", fifo_level, 16);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_overflow", overflow, 1);
    clr_overflow = 1;
    cycle();
    clr_overflow = 0;
    chk("t3_ovf_cleared", overflow, 0);

    // Full FIFO while the FSM pops in LOAD: the concurrent push is still dropped
    uart_ready = 1;
    cycle();
    uart_ready = 0;
    budget = 0;
    while (!m_load && budget < 1000) begin
      cycle();
      budget++;
    end
    chk("t4_load_timeout", budget < 1000, 1);
    in_valid = 1; in_data = 16'hDEAD;
    cycle();
    in_valid = 0;
    chk("t4_level", fifo_level, 15);
    chk("t4_overflow", overflow, 1);
    chk("t4_data", uart_data, 16'h0101);

    // Reset at hold count 300
    auto_rdy = 1; rdly = 2;
    budget = 0;
    while (!m_in_hold() && budget < 50) begin
      cycle();
      budget++;
    end
    chk("t5_hold_timeout", budget < 50, 1);
    repeat (GUARD - 1 - 300) cycle();
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_ena", uart_ena, 0);
    chk("t5_rst_data", uart_data, 0);
    chk("t5_rst_level", fifo_level, 0);
    chk("t5_rst_ovf", overflow, 0);
    model_reset();
    uart_ready = 0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    rises.delete(); rise_data.delete();
    repeat (50) cycle();
    chk("t5_no_request", rises.size(), 0);

    // Randomized traffic against the model
    rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 29) == 0);
      in_data = 16'($urandom);
      clr_overflow = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
